// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------------------
// digit_serial_adder
//
// Digit-serial two's complement adder/subtractor. A WIDTH-bit operand pair
// is consumed DIGIT bits per clock, least significant digit first, through a
// ripple chain of DIGIT full-adder cells. The carry between digits is held
// in a flop, so the combinational path is one DIGIT-bit ripple no matter how
// wide the operands are.
//
// Parameters
//   WIDTH  operand/result width in bits (WIDTH >= DIGIT, WIDTH % DIGIT == 0)
//   DIGIT  bits processed per clock; an operation takes WIDTH/DIGIT cycles
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request an operation (taken in IDLE or DONE, ignored in RUN)
//   sub    in   0: a+b, 1: a-b; sampled with start
//   a, b   in   WIDTH-bit operands; sampled with start
//   busy   out  high while digits are being processed
//   done   out  one-cycle pulse when a new result is presented
//   sum    out  WIDTH-bit result (modulo 2^WIDTH)
//   cout   out  carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------

// Single-bit full adder cell used to build each digit slice.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  // A single-step configuration still needs a one-bit counter to exist.
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // Refuse to elaborate a configuration that cannot tile the operand.
  if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operand shift registers; the low DIGIT bits feed the adder slice.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;

  // Partial result being assembled; digits enter at the top and move down.
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;

  // Carry passed from one digit to the next.
  logic             carry;
  logic [CW-1:0]    cnt;

  // Result registers that drive the outputs; they only change when an
  // operation completes so observers never see a partially built sum.
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Ripple chain across one digit: c[0] is the stored carry, c[DIGIT] is the
  // carry leaving the digit, c[DIGIT-1] the carry into its top bit.
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;

  logic accept;
  logic last_step;

  // A new operation is taken whenever the unit is not mid-computation, which
  // lets a start in the DONE cycle chain straight into the next operation.
  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == LAST);

  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .x  (a_sr[i]),
      .y  (b_sr[i]),
      .ci (c[i]),
      .s  (dsum[i]),
      .co (c[i+1])
    );
  end

  // The result register shifts right by one digit and the fresh digit lands
  // in the top DIGIT bits. After STEPS shifts the first digit has reached
  // bit 0. Writing the shift as a whole-register operation keeps it valid
  // when DIGIT equals WIDTH.
  always_comb begin
    res_next                   = res_sr >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = dsum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: status decodes the state, results come from the result
  // registers.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

  // Datapath. Subtraction is a + ~b + 1: B is inverted on capture and the
  // "+1" is injected as the initial carry. On the final digit the assembled
  // result and both MSB carries are committed to the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_next;
      carry  <= c[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        sum_q  <= res_next;
        cout_q <= c[DIGIT];
        ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Bench for digit_serial_adder. Two 8-bit instances (DIGIT=1 and DIGIT=4)
// run the directed vectors; four 16-bit instances (DIGIT=1,2,4,16) share a
// random regression against the a+b / a-b reference. Expected results are
// queued when an operation is issued and a negedge monitor pops one entry
// per done pulse.
// ---------------------------------------------------------------------------
module tb_digit_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res8_t;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res16_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]      start8;
  logic            sub8;
  logic [7:0]      a8;
  logic [7:0]      b8;
  logic [1:0]      busy8;
  logic [1:0]      done8;
  logic [1:0][7:0] sum8;
  logic [1:0]      cout8;
  logic [1:0]      ovf8;

  logic             rs_start;
  logic             rs_sub;
  logic [15:0]      ra;
  logic [15:0]      rb;
  logic [3:0]       r_busy;
  logic [3:0]       r_done;
  logic [3:0][15:0] r_sum;
  logic [3:0]       r_cout;
  logic [3:0]       r_ovf;

  res8_t  q8[2][$];
  res16_t rq[4][$];
  res8_t  m8;
  res16_t m16;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Directed 8-bit instances
  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8[0]),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8[0]),
    .done  (done8[0]),
    .sum   (sum8[0]),
    .cout  (cout8[0]),
    .ovf   (ovf8[0])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8[1]),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8[1]),
    .done  (done8[1]),
    .sum   (sum8[1]),
    .cout  (cout8[1]),
    .ovf   (ovf8[1])
  );

  // Random-regression 16-bit instances
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    digit_serial_adder #(.WIDTH(16), .DIGIT(D)) u_rnd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (rs_start),
      .sub   (rs_sub),
      .a     (ra),
      .b     (rb),
      .busy  (r_busy[g]),
      .done  (r_done[g]),
      .sum   (r_sum[g]),
      .cout  (r_cout[g]),
      .ovf   (r_ovf[g])
    );
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation to 8-bit instance sel; returns 1ns after the edge
  // that sampled start. With now=1 start is driven in the current cycle.
  task automatic apply_stimulus(input int sel, input bit now, input logic s,
                                input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] es, input logic ec,
                                input logic eo);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    start8[sel] = 1'b1;
    sub8        = s;
    a8          = x;
    b8          = y;
    q8[sel].push_back(res8_t'{es, ec, eo});
    @(posedge clk);
    #1;
    start8[sel] = 1'b0;
    check_output($sformatf("busy_after_start_%0d", sel), busy8[sel], 1);
  endtask

  // Count edges after the start edge until done, bounded; also drops start.
  task automatic wait_done(input int sel, input int exp_lat, input string name);
    int  j;
    bit  seen;
    j    = 0;
    seen = 1'b0;
    while (!seen && j < 40) begin
      @(posedge clk);
      #1;
      j++;
      start8[sel] = 1'b0;
      seen        = done8[sel];
    end
    if (!seen) j = 99;
    check_output($sformatf("%s_%0d", name, sel), j, exp_lat);
  endtask

  task automatic run_directed(input int sel, input int lat);
    int pre;
    // Reset state
    rst_n  = 1'b0;
    start8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", busy8[sel], 0);
    check_output("rst_done", done8[sel], 0);
    check_output("rst_sum", sum8[sel], 0);
    check_output("rst_cout", cout8[sel], 0);
    check_output("rst_ovf", ovf8[sel], 0);

    // start held across reset release: 5A+33
    start8[sel] = 1'b1;
    sub8        = 1'b0;
    a8          = 8'h5A;
    b8          = 8'h33;
    q8[sel].push_back(res8_t'{8'h8D, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start8[sel] = 1'b0;
    check_output($sformatf("busy_after_release_%0d", sel), busy8[sel], 1);
    wait_done(sel, lat, "lat_5a_33");
    @(posedge clk);
    #1;
    check_output("done_one_cycle", done8[sel], 0);
    check_output("busy_after_done", busy8[sel], 0);

    apply_stimulus(sel, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    wait_done(sel, lat, "lat_ff_01");
    apply_stimulus(sel, 1'b0, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    wait_done(sel, lat, "lat_10_sub_20");
    apply_stimulus(sel, 1'b0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    wait_done(sel, lat, "lat_80_sub_01");

    // Asynchronous reset between edges clears outputs with no clock
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_sum", sum8[sel], 0);
    check_output("async_rst_cout", cout8[sel], 0);
    check_output("async_rst_ovf", ovf8[sel], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start during RUN is ignored
    apply_stimulus(sel, 1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
    start8[sel] = 1'b1;
    sub8        = 1'b1;
    a8          = 8'hFF;
    b8          = 8'hFF;
    wait_done(sel, lat, "lat_ignored_start");

    // Back-to-back start in the DONE cycle; previous result is held
    apply_stimulus(sel, 1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    check_output("sum_held", sum8[sel], 8'h46);
    wait_done(sel, lat, "lat_back_to_back");

    // Reset in the middle of an operation: no done, outputs cleared
    pre = (lat > 3) ? 3 : 1;
    apply_stimulus(sel, 1'b0, 1'b0, 8'h77, 8'h11, 8'h88, 1'b0, 1'b1);
    repeat (pre) @(posedge clk);
    #3;
    rst_n = 1'b0;
    void'(q8[sel].pop_back());
    #1;
    check_output("midrst_busy", busy8[sel], 0);
    check_output("midrst_done", done8[sel], 0);
    check_output("midrst_sum", sum8[sel], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(sel, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    wait_done(sel, lat, "lat_after_midrst");
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int count);
    logic [15:0] bb;
    logic [16:0] tot;
    logic        ov;
    for (int v = 0; v < count; v++) begin
      @(posedge clk);
      #1;
      rs_sub   = 1'($urandom_range(0, 1));
      ra       = 16'($urandom);
      rb       = 16'($urandom);
      rs_start = 1'b1;
      bb       = rs_sub ? ~rb : rb;
      tot      = 17'(ra) + 17'(bb) + 17'(rs_sub);
      ov       = (ra[15] == bb[15]) && (tot[15] != ra[15]);
      for (int i = 0; i < 4; i++) begin
        rq[i].push_back(res16_t'{tot[15:0], tot[16], ov});
      end
      @(posedge clk);
      #1;
      rs_start = 1'b0;
      repeat (17) @(posedge clk);
    end
  endtask

  // Scoreboard monitor: one queued expectation per done pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done8[i]) begin
        if (q8[i].size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL spurious_done8_%0d: got done=1, expected no done", i);
        end else begin
          m8 = q8[i].pop_front();
          check_output($sformatf("sum8_%0d", i), sum8[i], m8.s);
          check_output($sformatf("cout8_%0d", i), cout8[i], m8.c);
          check_output($sformatf("ovf8_%0d", i), ovf8[i], m8.o);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r_done[i]) begin
        if (rq[i].size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL spurious_done16_%0d: got done=1, expected no done", i);
        end else begin
          m16 = rq[i].pop_front();
          check_output($sformatf("sum16_%0d", i), r_sum[i], m16.s);
          check_output($sformatf("cout16_%0d", i), r_cout[i], m16.c);
          check_output($sformatf("ovf16_%0d", i), r_ovf[i], m16.o);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start8   = '0;
    sub8     = 1'b0;
    a8       = '0;
    b8       = '0;
    rs_start = 1'b0;
    rs_sub   = 1'b0;
    ra       = '0;
    rb       = '0;

    run_directed(0, 8);
    run_directed(1, 2);
    run_random(1000);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("q8_drained_%0d", i), q8[i].size(), 0);
    end
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("q16_drained_%0d", i), rq[i].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
